// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter_if : IF/LS requester ports and memory port of the arbiter |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface mem_arbiter_if #(
  parameter int WORD = 32,
  parameter int ADDR = 16
);
  // Instruction-fetch port (read only)
  logic            if_req_i;
  logic [ADDR-1:0] if_addr_i;
  logic            if_gnt_o;
  logic            if_rvalid_o;
  logic [WORD-1:0] if_rdata_o;

  // Load/store port
  logic            ls_req_i;
  logic            ls_we_i;
  logic [ADDR-1:0] ls_addr_i;
  logic [WORD-1:0] ls_wdata_i;
  logic            ls_gnt_o;
  logic            ls_rvalid_o;
  logic [WORD-1:0] ls_rdata_o;

  // Single-ported memory, one-cycle read latency
  logic [ADDR-1:0] mem_addr_o;
  logic            mem_write_o;
  logic [WORD-1:0] mem_din_o;
  logic [WORD-1:0] mem_dout_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_addr_o, mem_write_o, mem_din_o,
    input  mem_dout_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_addr_o, mem_write_o, mem_din_o,
    output mem_dout_i
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter : shares one single-ported memory between IF and LS;      |
// | LS-priority with starvation-forced IF grant, read data steered back.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mem_arbiter #(
  parameter int WORD         = 32,
  parameter int ADDR         = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic    clk_i,
  input  wire logic    rst_i,
  mem_arbiter_if.slave bus
);

  localparam int               CNT_W        = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] c_STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic             c_OWNER_IF   = 1'b0;
  localparam logic             c_OWNER_LS   = 1'b1;

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_owner_q, rsp_owner_d;

  logic             w_force_if;
  logic             w_if_gnt;
  logic             w_ls_gnt;
  logic [ADDR-1:0]  w_mem_addr;
  logic             w_mem_write;
  logic [WORD-1:0]  w_mem_din;

  // Grant: LS by default, IF once it has waited STARVE_LIMIT cycles
  always_comb begin
    w_force_if = bus.if_req_i && (starve_q == c_STARVE_MAX);
    w_if_gnt   = 1'b0;
    w_ls_gnt   = 1'b0;
    if (!rst_i) begin
      if (w_force_if) begin
        w_if_gnt = 1'b1;
      end else if (bus.ls_req_i) begin
        w_ls_gnt = 1'b1;
      end else if (bus.if_req_i) begin
        w_if_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    w_mem_addr  = '0;
    w_mem_write = 1'b0;
    w_mem_din   = '0;
    if (w_if_gnt) begin
      w_mem_addr = bus.if_addr_i;
    end else if (w_ls_gnt) begin
      w_mem_addr  = bus.ls_addr_i;
      w_mem_write = bus.ls_we_i;
      w_mem_din   = bus.ls_wdata_i;
    end
  end

  // Writes produce no response; owner is left alone when nothing is pending
  always_comb begin
    rsp_valid_d = 1'b0;
    rsp_owner_d = rsp_owner_q;
    if (w_if_gnt) begin
      rsp_valid_d = 1'b1;
      rsp_owner_d = c_OWNER_IF;
    end else if (w_ls_gnt && !bus.ls_we_i) begin
      rsp_valid_d = 1'b1;
      rsp_owner_d = c_OWNER_LS;
    end
  end

  always_comb begin
    starve_d = '0;
    if (bus.if_req_i && !w_if_gnt) begin
      starve_d = (starve_q == c_STARVE_MAX) ? starve_q : starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= c_OWNER_IF;
      starve_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
      starve_q    <= starve_d;
    end
  end

  assign bus.if_gnt_o    = w_if_gnt;
  assign bus.ls_gnt_o    = w_ls_gnt;
  assign bus.mem_addr_o  = w_mem_addr;
  assign bus.mem_write_o = w_mem_write;
  assign bus.mem_din_o   = w_mem_din;

  assign bus.if_rvalid_o = rsp_valid_q && (rsp_owner_q == c_OWNER_IF);
  assign bus.ls_rvalid_o = rsp_valid_q && (rsp_owner_q == c_OWNER_LS);
  assign bus.if_rdata_o  = bus.mem_dout_i;
  assign bus.ls_rdata_o  = bus.mem_dout_i;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter : directed + random stimulus, reference model and     |
// | response scoreboard for mem_arbiter.  Revision: 1.0                  |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int WORD         = 32;
  localparam int ADDR         = 16;
  localparam int STARVE_LIMIT = 4;

  typedef struct {
    logic            owner;
    logic [WORD-1:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  mem_arbiter_if #(.WORD(WORD), .ADDR(ADDR)) bus ();

  mem_arbiter #(
    .WORD(WORD), .ADDR(ADDR), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural memory attached to the DUT
  logic [WORD-1:0] dmem [0:65535];
  logic [WORD-1:0] mdout = '0;
  always @(posedge clk) begin
    if (bus.mem_write_o) dmem[bus.mem_addr_o] <= bus.mem_din_o;
    mdout <= dmem[bus.mem_addr_o];
  end
  assign bus.mem_dout_i = mdout;

  // Reference model state
  logic [WORD-1:0] refmem [0:65535];
  int              m_starve = 0;
  rsp_t            rspq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Per-cycle reference check, sampled mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      logic e_force, e_if, e_ls;
      rsp_t e;
      e_force = bus.if_req_i && (m_starve == STARVE_LIMIT);
      e_if    = !rst && bus.if_req_i && (e_force || !bus.ls_req_i);
      e_ls    = !rst && bus.ls_req_i && !e_force;

      chk("if_gnt", bus.if_gnt_o, e_if);
      chk("ls_gnt", bus.ls_gnt_o, e_ls);
      chk("mem_write", bus.mem_write_o, e_ls && bus.ls_we_i);
      chk("mem_addr", bus.mem_addr_o,
          e_if ? bus.if_addr_i : (e_ls ? bus.ls_addr_i : 16'h0));
      if (e_ls) chk("mem_din", bus.mem_din_o, bus.ls_wdata_i);
      else if (!e_if) chk("mem_din_idle", bus.mem_din_o, 32'h0);

      if (rspq.size() > 0) begin
        e = rspq.pop_front();
        chk("if_rvalid", bus.if_rvalid_o, !e.owner);
        chk("ls_rvalid", bus.ls_rvalid_o, e.owner);
        chk(e.owner ? "ls_rdata" : "if_rdata",
            e.owner ? bus.ls_rdata_o : bus.if_rdata_o, e.data);
      end else begin
        chk("if_rvalid_idle", bus.if_rvalid_o, 1'b0);
        chk("ls_rvalid_idle", bus.ls_rvalid_o, 1'b0);
      end

      if (e_if) begin
        e.owner = 1'b0; e.data = refmem[bus.if_addr_i];
        rspq.push_back(e);
      end else if (e_ls && !bus.ls_we_i) begin
        e.owner = 1'b1; e.data = refmem[bus.ls_addr_i];
        rspq.push_back(e);
      end else if (e_ls) begin
        refmem[bus.ls_addr_i] = bus.ls_wdata_i;
      end

      if (rst) m_starve = 0;
      else if (bus.if_req_i && !e_if)
        m_starve = (m_starve == STARVE_LIMIT) ? m_starve : m_starve + 1;
      else m_starve = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ireq, input logic [15:0] iaddr,
                       input logic lreq, input logic lwe,
                       input logic [15:0] laddr, input logic [31:0] lwdata);
    bus.if_req_i   = ireq;
    bus.if_addr_i  = iaddr;
    bus.ls_req_i   = lreq;
    bus.ls_we_i    = lwe;
    bus.ls_addr_i  = laddr;
    bus.ls_wdata_i = lwdata;
  endtask

  logic [11:0] pat_if, pat_ls;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      dmem[i]   = '0;
      refmem[i] = '0;
    end
    dmem[16'h0010]   = 32'h12345678;
    refmem[16'h0010] = 32'h12345678;

    // Reset held with both requests pending and a write offered
    rst = 1'b1;
    drive(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0020, 32'h11111111);
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    cyc();

    // IF-only read of preloaded word
    drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 32'h0);
    cyc();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    cyc();

    // LS write then read back
    drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h0020, 32'hDEADBEEF);
    cyc();
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 32'h0);
    cyc();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    cyc();

    // Continuous contention: IF forced through once every STARVE_LIMIT+1
    drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, 32'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pat_if[i] = bus.if_gnt_o;
      pat_ls[i] = bus.ls_gnt_o;
      cyc();
    end
    chk("if_grant_pattern", {20'h0, pat_if}, 32'h210);
    chk("ls_grant_pattern", {20'h0, pat_ls}, 32'hDEF);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    cyc();

    // Same-cycle LS write and IF read of the same address
    drive(1'b1, 16'h0030, 1'b1, 1'b1, 16'h0030, 32'hCAFEF00D);
    cyc();
    drive(1'b1, 16'h0030, 1'b0, 1'b0, 16'h0, 32'h0);
    cyc();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    cyc();
    cyc();

    // Reset in an IF grant cycle, after the counter has built up
    drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, 32'h0);
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (6) cyc();
    drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 32'h0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    cyc();

    // Reset in a response cycle: the registered rvalid still shows
    drive(1'b1, 16'h0030, 1'b0, 1'b0, 16'h0, 32'h0);
    cyc();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();

    // Random traffic on a small address window
    for (int i = 0; i < 200; i++) begin
      rst = ($urandom_range(0, 29) == 0);
      drive(1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            16'($urandom_range(0, 7)), $urandom);
      cyc();
    end
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    repeat (2) cyc();

    chk("scoreboard_drained", rspq.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
